// File: rtl/jtdsp16_pkg.sv
// rtl/jtdsp16_pkg.sv - shared state encoding and cache constants for the do/redo sequencer
package jtdsp16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REPLAY = 2'd2
    } do_state_t;

    localparam int CACHE_DEPTH = 15;
    localparam int KMAX        = 127;

endpackage

// File: rtl/jtdsp16_do_cache.sv
// rtl/jtdsp16_do_cache.sv - 15x16 loop-body register file, one write port, one async read port
module jtdsp16_do_cache
    import jtdsp16_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int DEPTH = CACHE_DEPTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; only slots written during LOAD are ever read.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem_q[waddr] <= din;
        end
    end

    assign dout = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/jtdsp16_do_ctl.sv
// rtl/jtdsp16_do_ctl.sv - do/redo loop sequencer: loads a body into the cache, then replays it
module jtdsp16_do_ctl
    import jtdsp16_pkg::*;
#(
    parameter int CW = 4,
    parameter int KW = 7
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          ins_adv,
    input  logic          do_req,
    input  logic          redo_req,
    input  logic [CW-1:0] ni,
    input  logic [KW-1:0] k,
    input  logic [15:0]   rom_dout,
    output logic [15:0]   cache_dout,
    output logic          use_cache,
    output logic          pc_halt,
    output logic          busy,
    output logic [KW-1:0] iter_left
);

    localparam logic [CW-1:0] PTR_ONE  = CW'(1);
    localparam logic [KW-1:0] ITER_ONE = KW'(1);

    do_state_t     state_q, state_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] n_q, n_d;
    logic [KW-1:0] iter_q, iter_d;
    logic          use_cache_q, pc_halt_q, busy_q;

    logic [KW-1:0] k_eff;
    logic [CW-1:0] n_last;
    logic          cache_we;

    // K=0 in the instruction is treated as a single pass.
    assign k_eff    = (k == '0) ? ITER_ONE : k;
    assign n_last   = n_q - PTR_ONE;
    assign cache_we = cen && ins_adv && (state_q == ST_LOAD);

    // Next-state logic: IDLE accepts requests (do wins), LOAD/REPLAY step one slot per retire.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        n_d     = n_q;
        iter_d  = iter_q;
        unique case (state_q)
            ST_IDLE: begin
                if (do_req) begin
                    if (ni != '0) begin
                        n_d     = ni;
                        iter_d  = k_eff;
                        ptr_d   = '0;
                        state_d = ST_LOAD;
                    end
                end else if (redo_req && (n_q != '0)) begin
                    iter_d  = k_eff;
                    ptr_d   = '0;
                    state_d = ST_REPLAY;
                end
            end
            ST_LOAD, ST_REPLAY: begin
                if (ins_adv) begin
                    if (ptr_q != n_last) begin
                        ptr_d = ptr_q + PTR_ONE;
                    end else begin
                        ptr_d   = '0;
                        iter_d  = iter_q - ITER_ONE;
                        state_d = (iter_q == ITER_ONE) ? ST_IDLE : ST_REPLAY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; outputs follow the next state so the switch to cache is bubble-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            n_q         <= '0;
            iter_q      <= '0;
            use_cache_q <= 1'b0;
            pc_halt_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else if (cen) begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            n_q         <= n_d;
            iter_q      <= iter_d;
            use_cache_q <= (state_d == ST_REPLAY);
            pc_halt_q   <= (state_d == ST_REPLAY);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    jtdsp16_do_cache #(
        .AW (CW),
        .DW (16)
    ) u_cache (
        .clk   (clk),
        .we    (cache_we),
        .waddr (ptr_q),
        .din   (rom_dout),
        .raddr (ptr_q),
        .dout  (cache_dout)
    );

    assign use_cache = use_cache_q;
    assign pc_halt   = pc_halt_q;
    assign busy      = busy_q;
    // iter reaches 0 on every exit path, so it already reads 0 in IDLE.
    assign iter_left = iter_q;

endmodule

// File: tb/tb_jtdsp16_do_ctl.sv
// tb/tb_jtdsp16_do_ctl.sv - directed self-checking bench for the do/redo loop sequencer
module tb_jtdsp16_do_ctl;

    logic        rst, clk, cen, ins_adv, do_req, redo_req;
    logic [3:0]  ni;
    logic [6:0]  k;
    logic [15:0] rom_dout;
    logic [15:0] cache_dout;
    logic        use_cache, pc_halt, busy;
    logic [6:0]  iter_left;

    int total = 0;
    int bad   = 0;

    logic [15:0] w3 [3] = '{16'hA001, 16'hB002, 16'hC003};
    logic [15:0] w4 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    jtdsp16_do_ctl dut (
        .rst        (rst),
        .clk        (clk),
        .cen        (cen),
        .ins_adv    (ins_adv),
        .do_req     (do_req),
        .redo_req   (redo_req),
        .ni         (ni),
        .k          (k),
        .rom_dout   (rom_dout),
        .cache_dout (cache_dout),
        .use_cache  (use_cache),
        .pc_halt    (pc_halt),
        .busy       (busy),
        .iter_left  (iter_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic req(input logic d, input logic r, input logic [3:0] n, input logic [6:0] kk);
        do_req = d; redo_req = r; ni = n; k = kk; ins_adv = 1'b0;
        @(negedge clk);
        do_req = 1'b0; redo_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b1; ins_adv = 1'b0; do_req = 1'b0; redo_req = 1'b0;
        ni = '0; k = '0; rom_dout = '0;
        @(negedge clk); @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL reset_use_cache got=%b exp=0", use_cache); end
        total++; if (pc_halt !== 1'b0) begin bad++; $display("FAIL reset_pc_halt got=%b exp=0", pc_halt); end
        total++; if (iter_left !== 7'd0) begin bad++; $display("FAIL reset_iter got=%0d exp=0", iter_left); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_do_basic();
        req(1'b1, 1'b0, 4'd3, 7'd2);
        for (int i = 0; i < 3; i++) begin
            rom_dout = w3[i]; ins_adv = 1'b1;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL do_load_busy[%0d] got=%b exp=1", i, busy); end
            total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL do_load_use_cache[%0d] got=%b exp=0", i, use_cache); end
            total++; if (iter_left !== 7'd2) begin bad++; $display("FAIL do_load_iter[%0d] got=%0d exp=2", i, iter_left); end
            @(negedge clk);
        end
        rom_dout = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            total++; if (use_cache !== 1'b1) begin bad++; $display("FAIL do_rep_use_cache[%0d] got=%b exp=1", i, use_cache); end
            total++; if (pc_halt !== 1'b1) begin bad++; $display("FAIL do_rep_pc_halt[%0d] got=%b exp=1", i, pc_halt); end
            total++; if (cache_dout !== w3[i]) begin bad++; $display("FAIL do_rep_data[%0d] got=%h exp=%h", i, cache_dout, w3[i]); end
            total++; if (iter_left !== 7'd1) begin bad++; $display("FAIL do_rep_iter[%0d] got=%0d exp=1", i, iter_left); end
            @(negedge clk);
        end
        ins_adv = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL do_end_busy got=%b exp=0", busy); end
        total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL do_end_use_cache got=%b exp=0", use_cache); end
        total++; if (iter_left !== 7'd0) begin bad++; $display("FAIL do_end_iter got=%0d exp=0", iter_left); end
    endtask

    task automatic test_redo();
        req(1'b0, 1'b1, 4'd0, 7'd3);
        rom_dout = 16'hBEEF;
        for (int i = 0; i < 9; i++) begin
            ins_adv = 1'b1;
            if (i == 8) begin do_req = 1'b1; ni = 4'd2; k = 7'd2; end
            total++; if (use_cache !== 1'b1) begin bad++; $display("FAIL redo_use_cache[%0d] got=%b exp=1", i, use_cache); end
            total++; if (cache_dout !== w3[i % 3]) begin bad++; $display("FAIL redo_data[%0d] got=%h exp=%h", i, cache_dout, w3[i % 3]); end
            total++; if (iter_left !== 7'(3 - i / 3)) begin bad++; $display("FAIL redo_iter[%0d] got=%0d exp=%0d", i, iter_left, 3 - i / 3); end
            @(negedge clk);
        end
        do_req = 1'b0; ins_adv = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL redo_end_busy got=%b exp=0", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL redo_dropped_do got=%b exp=0", busy); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        req(1'b0, 1'b1, 4'd0, 7'd3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL redo_after_rst_busy got=%b exp=0", busy); end
        total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL redo_after_rst_use_cache got=%b exp=0", use_cache); end
    endtask

    task automatic test_long();
        req(1'b1, 1'b0, 4'd1, 7'd127);
        rom_dout = 16'h5A5A; ins_adv = 1'b1;
        total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL long_load_use_cache got=%b exp=0", use_cache); end
        total++; if (iter_left !== 7'd127) begin bad++; $display("FAIL long_load_iter got=%0d exp=127", iter_left); end
        @(negedge clk);
        rom_dout = 16'h0000;
        for (int j = 0; j < 126; j++) begin
            total++; if (use_cache !== 1'b1) begin bad++; $display("FAIL long_use_cache[%0d] got=%b exp=1", j, use_cache); end
            total++; if (cache_dout !== 16'h5A5A) begin bad++; $display("FAIL long_data[%0d] got=%h exp=5a5a", j, cache_dout); end
            total++; if (iter_left !== 7'(126 - j)) begin bad++; $display("FAIL long_iter[%0d] got=%0d exp=%0d", j, iter_left, 126 - j); end
            @(negedge clk);
        end
        ins_adv = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL long_end_busy got=%b exp=0", busy); end
        total++; if (iter_left !== 7'd0) begin bad++; $display("FAIL long_end_iter got=%0d exp=0", iter_left); end
    endtask

    task automatic test_zero();
        req(1'b1, 1'b0, 4'd0, 7'd5);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL n0_busy got=%b exp=0", busy); end
        ins_adv = 1'b1; @(negedge clk); ins_adv = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL n0_busy_later got=%b exp=0", busy); end
        req(1'b1, 1'b0, 4'd2, 7'd0);
        for (int i = 0; i < 2; i++) begin
            rom_dout = 16'h7000 + 16'(i); ins_adv = 1'b1;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL k0_busy[%0d] got=%b exp=1", i, busy); end
            total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL k0_use_cache[%0d] got=%b exp=0", i, use_cache); end
            total++; if (iter_left !== 7'd1) begin bad++; $display("FAIL k0_iter[%0d] got=%0d exp=1", i, iter_left); end
            @(negedge clk);
        end
        ins_adv = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL k0_end_busy got=%b exp=0", busy); end
        total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL k0_end_use_cache got=%b exp=0", use_cache); end
    endtask

    task automatic test_gaps();
        int phase = 1;
        int ptr = 0;
        int iter = 2;
        bit injected = 1'b0;
        int cyc = 0;
        req(1'b1, 1'b0, 4'd3, 7'd2);
        while (phase != 0 && cyc < 300) begin
            cen = ((cyc % 7) != 4);
            ins_adv = 1'($urandom_range(0, 1));
            rom_dout = (phase == 1) ? w3[ptr] : 16'hFFFF;
            if (phase == 2 && !injected) begin
                do_req = 1'b1; ni = 4'd2; k = 7'd5; injected = 1'b1;
            end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy[%0d] got=%b exp=1", cyc, busy); end
            total++; if (use_cache !== (phase == 2)) begin bad++; $display("FAIL gap_use_cache[%0d] got=%b exp=%0d", cyc, use_cache, phase == 2); end
            total++; if (iter_left !== 7'(iter)) begin bad++; $display("FAIL gap_iter[%0d] got=%0d exp=%0d", cyc, iter_left, iter); end
            if (phase == 2) begin
                total++; if (cache_dout !== w3[ptr]) begin bad++; $display("FAIL gap_data[%0d] got=%h exp=%h", cyc, cache_dout, w3[ptr]); end
            end
            @(negedge clk);
            do_req = 1'b0;
            if (cen && ins_adv) begin
                if (ptr != 2) ptr++;
                else begin
                    ptr = 0; iter--;
                    phase = (iter == 0) ? 0 : 2;
                end
            end
            cyc++;
        end
        cen = 1'b1; ins_adv = 1'b0;
        total++; if (phase != 0) begin bad++; $display("FAIL gap_timeout got=%0d exp=0", phase); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_end_busy got=%b exp=0", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_req_dropped got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        req(1'b1, 1'b0, 4'd4, 7'd3);
        for (int i = 0; i < 5; i++) begin
            rom_dout = (i < 4) ? w4[i] : 16'h0000; ins_adv = 1'b1;
            @(negedge clk);
        end
        ins_adv = 1'b0;
        total++; if (cache_dout !== w4[1]) begin bad++; $display("FAIL mid_slot1_data got=%h exp=%h", cache_dout, w4[1]); end
        total++; if (use_cache !== 1'b1) begin bad++; $display("FAIL mid_slot1_use_cache got=%b exp=1", use_cache); end
        total++; if (iter_left !== 7'd2) begin bad++; $display("FAIL mid_slot1_iter got=%0d exp=2", iter_left); end
        #2 rst = 1'b1;
        #1;
        total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL mid_rst_use_cache got=%b exp=0", use_cache); end
        total++; if (pc_halt !== 1'b0) begin bad++; $display("FAIL mid_rst_pc_halt got=%b exp=0", pc_halt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        total++; if (iter_left !== 7'd0) begin bad++; $display("FAIL mid_rst_iter got=%0d exp=0", iter_left); end
        @(negedge clk);
        rst = 1'b0;
        req(1'b0, 1'b1, 4'd0, 7'd1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_redo_busy got=%b exp=0", busy); end
        @(negedge clk);
        total++; if (use_cache !== 1'b0) begin bad++; $display("FAIL mid_redo_use_cache got=%b exp=0", use_cache); end
    endtask

    initial begin
        test_reset();
        test_do_basic();
        test_redo();
        test_long();
        test_zero();
        test_gaps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
